// File: rtl/pixwr_pkg.sv
// pixwr_pkg: shared constants, the FSM state type, the FIFO entry type and the
// address/visibility helpers used by pixel_writer and pix_fifo.
package pixwr_pkg;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned COLOR_W    = 3;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned LAST_ADDR  = 19199;
  localparam int unsigned X_W        = 8;
  localparam int unsigned Y_W        = 7;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  // y*160 + x built from shifts (128 + 32) so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

  function automatic logic on_screen(input logic [X_W-1:0] x,
                                     input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: FIFO_DEPTH-entry pixel buffer.
// Ports: clk/rst (async active-high), push/din write side, pop/dout read side,
//        full, empty, count. A push on a full FIFO is refused even if a pop
//        happens in the same cycle. full/empty/count come from registered
//        state only, so there is no combinational path from push to empty.
module pix_fifo
  import pixwr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pix_t             din,
  input  logic             pop,
  output pix_t             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  pix_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: buffers pixels from the circle drawer and writes them to a
// 160x120 video RAM (vaddr = y*160 + x), dropping off-screen pixels.
// Optional screen clear (macro PIXWR_CLEAR_EN): a clear pulse is held pending
// until queued pixels drain, then addresses 0..19199 are written with zero.
// Ports: CLK50, RST (async active-high); xi/yi/color/pix_valid/pix_ready
//        pixel input handshake; clear request; busy status;
//        vaddr/vdata/vwe registered video RAM write port.
module pixel_writer
  import pixwr_pkg::*;
(
  input  logic               CLK50,
  input  logic               RST,
  input  logic [X_W-1:0]     xi,
  input  logic [Y_W-1:0]     yi,
  input  logic [COLOR_W-1:0] color,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic               clear,
  output logic               busy,
  output logic [ADDR_W-1:0]  vaddr,
  output logic [COLOR_W-1:0] vdata,
  output logic               vwe
);

  state_t             state_q, state_d;
  logic               vwe_q, vwe_d;
  logic [ADDR_W-1:0]  vaddr_q, vaddr_d;
  logic [COLOR_W-1:0] vdata_q, vdata_d;

  logic               push, pop, full, empty;
  logic [CNT_W-1:0]   count;
  pix_t               in_pix, head;

`ifdef PIXWR_CLEAR_EN
  logic               clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0]  sweep_q, sweep_d;
`endif

  assign in_pix = '{x: xi, y: yi, c: color};
  assign push   = pix_valid && pix_ready;

  pix_fifo u_fifo (
    .clk   (CLK50),
    .rst   (RST),
    .push  (push),
    .din   (in_pix),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef PIXWR_CLEAR_EN
  assign pix_ready = !RST && (count < CNT_W'(FIFO_DEPTH)) && (state_q != CLEAR) && !clr_pend_q;
  assign busy      = !empty || vwe_q || clr_pend_q || (state_q == CLEAR);
`else
  logic unused_in;
  assign unused_in = clear ^ full;
  assign pix_ready = !RST && (count < CNT_W'(FIFO_DEPTH));
  assign busy      = !empty || vwe_q;
`endif

  always_comb begin
    pop     = !empty && (state_q != CLEAR);
    vwe_d   = pop && on_screen(head.x, head.y);
    vaddr_d = vaddr_q;
    vdata_d = vdata_q;
    state_d = state_q;
    if (pop) begin
      vaddr_d = pix_addr(head.x, head.y);
      vdata_d = head.c;
    end
    if (state_q != CLEAR) begin
      if (push)                                  state_d = DRAW;
      else if (pop && (count == CNT_W'(1)))      state_d = IDLE;
    end
`ifdef PIXWR_CLEAR_EN
    clr_pend_d = clr_pend_q;
    sweep_d    = sweep_q;
    if (clear && (state_q != CLEAR)) clr_pend_d = 1'b1;
    if (state_q == CLEAR) begin
      vwe_d   = 1'b1;
      vaddr_d = sweep_q;
      vdata_d = '0;
      if (sweep_q == ADDR_W'(LAST_ADDR)) begin
        sweep_d    = '0;
        clr_pend_d = 1'b0;
        state_d    = IDLE;
      end else begin
        sweep_d = sweep_q + ADDR_W'(1);
      end
    end else if (empty && clr_pend_q) begin
      // pix_ready is low while pending, so no push can race this transition.
      state_d = CLEAR;
    end
`endif
  end

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      vwe_q      <= 1'b0;
      vaddr_q    <= '0;
      vdata_q    <= '0;
`ifdef PIXWR_CLEAR_EN
      clr_pend_q <= 1'b0;
      sweep_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vwe_q      <= vwe_d;
      vaddr_q    <= vaddr_d;
      vdata_q    <= vdata_d;
`ifdef PIXWR_CLEAR_EN
      clr_pend_q <= clr_pend_d;
      sweep_q    <= sweep_d;
`endif
    end
  end

  assign vwe   = vwe_q;
  assign vaddr = vaddr_q;
  assign vdata = vdata_q;

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed bench for pixel_writer. Inputs change and outputs
// are checked 1 ns after each rising edge; a negedge monitor logs every
// video RAM write as {vaddr, vdata} for ordered comparison.
module tb_pixel_writer;

  logic        CLK50 = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  xi = '0;
  logic [6:0]  yi = '0;
  logic [2:0]  color = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        clear = 1'b0;
  logic        busy;
  logic [14:0] vaddr;
  logic [2:0]  vdata;
  logic        vwe;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [17:0] wq[$];
  bit          watch_rdy = 1'b0;
  bit          rdy_seen = 1'b0;

  always #5 CLK50 = ~CLK50;

  pixel_writer dut (
    .CLK50     (CLK50),
    .RST       (RST),
    .xi        (xi),
    .yi        (yi),
    .color     (color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .clear     (clear),
    .busy      (busy),
    .vaddr     (vaddr),
    .vdata     (vdata),
    .vwe       (vwe)
  );

  always @(negedge CLK50) begin
    if (vwe) wq.push_back({vaddr, vdata});
    if (watch_rdy && pix_ready) rdy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK50);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic drive_pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    xi = x;
    yi = y;
    color = c;
    pix_valid = 1'b1;
  endtask

  initial begin
    logic [7:0]  px [6];
    logic [6:0]  py [6];
    logic [2:0]  pc [6];
    int unsigned first_bad;
    int unsigned n_w;
    bit          hit;

    // Reset state
    ticks(2);
    check("rst_vwe",   32'(vwe), 32'd0);
    check("rst_vaddr", 32'(vaddr), 32'd0);
    check("rst_vdata", 32'(vdata), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    RST = 1'b0;
    tick();
    check("post_rst_ready", 32'(pix_ready), 32'd1);

    // Single pixel latency: (10,5) -> 5*160+10 = 810
    wq.delete();
    drive_pix(8'd10, 7'd5, 3'b101);
    tick();
    pix_valid = 1'b0;
    check("lat_k_vwe",  32'(vwe), 32'd0);
    check("lat_k_busy", 32'(busy), 32'd1);
    tick();
    check("lat_k1_vwe",   32'(vwe), 32'd1);
    check("lat_k1_vaddr", 32'(vaddr), 32'd810);
    check("lat_k1_vdata", 32'(vdata), 32'd5);
    tick();
    check("lat_k2_vwe",  32'(vwe), 32'd0);
    check("lat_k2_busy", 32'(busy), 32'd0);

    // Six back-to-back pixels
    wq.delete();
    for (int i = 0; i < 6; i++) begin
      px[i] = 8'(20 + i);
      py[i] = 7'(2 * i);
      pc[i] = 3'(i + 1);
    end
    for (int i = 0; i < 6; i++) begin
      drive_pix(px[i], py[i], pc[i]);
      check($sformatf("b2b_ready%0d", i), 32'(pix_ready), 32'd1);
      tick();
    end
    pix_valid = 1'b0;
    ticks(4);
    check("b2b_count", wq.size(), 32'd6);
    for (int i = 0; i < 6 && i < wq.size(); i++)
      check($sformatf("b2b_wr%0d", i), 32'(wq[i]),
            32'({15'(int'(py[i]) * 160 + int'(px[i])), pc[i]}));
    check("b2b_busy", 32'(busy), 32'd0);

    // Off-screen boundaries
    wq.delete();
    drive_pix(8'd160, 7'd0, 3'b111);   tick();
    drive_pix(8'd0, 7'd120, 3'b111);   tick();
    drive_pix(8'd159, 7'd119, 3'b110); tick();
    pix_valid = 1'b0;
    ticks(4);
    check("edge_count", wq.size(), 32'd1);
    if (wq.size() > 0) check("edge_wr", 32'(wq[0]), 32'({15'd19199, 3'b110}));

`ifdef PIXWR_CLEAR_EN
    // Queue three pixels then clear; second clear mid-sweep is ignored
    wq.delete();
    drive_pix(8'd1, 7'd1, 3'd1); tick();
    drive_pix(8'd2, 7'd2, 3'd2); tick();
    drive_pix(8'd3, 7'd3, 3'd3); tick();
    pix_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rdy_seen = 1'b0;
    watch_rdy = 1'b1;
    hit = 1'b0;
    for (int unsigned i = 0; i < 20000; i++) begin
      tick();
      clear = (i == 100);
      if (vwe && vaddr == 15'd19199) watch_rdy = 1'b0;
      if (!busy) begin hit = 1'b1; break; end
    end
    watch_rdy = 1'b0;
    clear = 1'b0;
    check("clr_done", 32'(hit), 32'd1);
    ticks(5);
    check("clr_count", wq.size(), 32'd19203);
    if (wq.size() >= 3) begin
      check("clr_px0", 32'(wq[0]), 32'({15'd161, 3'd1}));
      check("clr_px1", 32'(wq[1]), 32'({15'd322, 3'd2}));
      check("clr_px2", 32'(wq[2]), 32'({15'd483, 3'd3}));
    end
    first_bad = 19200;
    for (int unsigned i = 0; i < 19200; i++) begin
      if (i + 3 >= wq.size() || wq[i + 3] != {15'(i), 3'b000}) begin
        first_bad = i;
        break;
      end
    end
    check("clr_sweep_first_bad", first_bad, 32'd19200);
    check("clr_ready_low", 32'(rdy_seen), 32'd0);
    check("clr_end_busy",  32'(busy), 32'd0);
    check("clr_end_ready", 32'(pix_ready), 32'd1);

    // Reset in the middle of a sweep
    clear = 1'b1;
    tick();
    clear = 1'b0;
    hit = 1'b0;
    for (int unsigned i = 0; i < 10000; i++) begin
      if (vwe && vaddr == 15'd5000) begin hit = 1'b1; break; end
      tick();
    end
    check("rst_sweep_hit", 32'(hit), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_sweep_vwe",   32'(vwe), 32'd0);
    check("rst_sweep_busy",  32'(busy), 32'd0);
    check("rst_sweep_ready", 32'(pix_ready), 32'd0);
    n_w = wq.size();
    ticks(2);
    RST = 1'b0;
    tick();
    check("rst_rel_ready", 32'(pix_ready), 32'd1);
    ticks(20);
    check("rst_no_writes", wq.size(), n_w);
    check("rst_rel_busy",  32'(busy), 32'd0);
`else
    // Clear input has no effect in this build
    wq.delete();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("noclr_busy1", 32'(busy), 32'd0);
    ticks(10);
    check("noclr_writes", wq.size(), 32'd0);
    check("noclr_busy2",  32'(busy), 32'd0);
    check("noclr_ready",  32'(pix_ready), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 CLK50  in  1  system clock; all state updates on the rising edge.
REQ-002 RST  in  1  asynchronous, active-high reset.
REQ-003 xi  in  8  pixel X coordinate from the circle drawer.
REQ-004 yi  in  7  pixel Y coordinate from the circle drawer.
REQ-005 color  in  3  pixel colour.
REQ-006 pix_valid  in  1  xi/yi/color valid this cycle.
REQ-007 pix_ready  out  1  block accepts a pixel this cycle.
REQ-008 clear  in  1  one-cycle request to clear the screen.
REQ-009 busy  out  1  work pending or in progress.
REQ-010 vaddr  out  15  video RAM address.
REQ-011 vdata  out  3  video RAM write data.
REQ-012 vwe  out  1  video RAM write enable, one write per high cycle.

Function
REQ-013 The block SHALL accept a pixel on every rising edge where pix_valid and pix_ready are both high; pixel_writer SHALL ignore pix_valid while pix_ready is low.
REQ-014 The block SHALL buffer accepted pixels in a 4-entry FIFO of {xi, yi, color}.
REQ-015 pix_ready SHALL equal (FIFO count < 4) AND (state != CLEAR) AND (no clear pending).
REQ-016 On a full FIFO, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-017 When the FIFO is non-empty in state IDLE or DRAW, the block SHALL pop one entry per edge; a push and a pop in the same edge on a non-full FIFO SHALL both take effect.
REQ-018 A popped entry SHALL be written as vaddr = y*160 + x, computed as (y<<7)+(y<<5)+x in 15 bits, with vdata = color.
REQ-019 The block SHALL drive vwe for one cycle only when x < 160 and y < 120; off-screen entries SHALL be popped with vwe = 0.
REQ-020 Latency: a pixel accepted at edge k into an empty FIFO SHALL have vwe/vaddr/vdata registered valid from edge k+1 to edge k+2.
REQ-021 The states SHALL be IDLE (FIFO empty), DRAW (FIFO non-empty) and CLEAR. IDLE->DRAW on push. DRAW->IDLE when the last entry pops and no push occurs. DRAW/IDLE->CLEAR when the FIFO is empty and a clear is pending.
REQ-022 A clear pulse in IDLE or DRAW SHALL set a pending flag. Queued pixels SHALL be written before CLEAR is entered.
REQ-023 In CLEAR, the block SHALL write vdata = 3'b000 with vwe = 1 to addresses 0..19199 ascending, one per cycle. After the write to 19199 it SHALL return to IDLE and clear the pending flag.
REQ-024 A clear pulse during CLEAR SHALL be ignored.
REQ-025 busy SHALL be high when the FIFO is non-empty, vwe is high, a clear is pending, or state is CLEAR; otherwise it SHALL be low.

Reset
REQ-026 On RST high, the block SHALL immediately force: state IDLE, FIFO empty, clear pending 0, sweep counter 0, vwe 0, vaddr 0, vdata 0, busy 0, pix_ready 0 while RST is held.
REQ-027 A reset during CLEAR or DRAW SHALL abandon the sweep and discard buffered pixels; no write SHALL complete after RST asserts.

Configuration
REQ-028 The macro PIXWR_CLEAR_EN SHALL control the clear feature.
REQ-029 With PIXWR_CLEAR_EN defined, the block SHALL implement the clear input, the pending flag, the CLEAR state and the sweep counter.
REQ-030 Without PIXWR_CLEAR_EN, the block SHALL ignore clear, the CLEAR state and counter SHALL be absent, pix_ready SHALL equal (count < 4), and busy SHALL equal (FIFO non-empty OR vwe).

Structure
REQ-031 Package pixwr_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, FIFO_DEPTH=4, COLOR_W=3, ADDR_W=15, LAST_ADDR=19199 and the state enum {IDLE, DRAW, CLEAR}.
REQ-032 The FIFO SHALL be a sub-module named pix_fifo (push, pop, full, empty, count), with no combinational path from push to empty.

Verification
REQ-033 Reset, then push (x=10, y=5, c=3'b101) -> next cycle vwe=1, vaddr=810, vdata=3'b101; busy then drops to 0.
REQ-034 Hold pix_valid with 6 pixels back-to-back -> pix_ready stays high while the FIFO drains at 1/cycle; 6 writes in order with no loss or duplication.
REQ-035 Push (x=160, y=0) then (x=0, y=120) then (x=159, y=119) -> only one write, vaddr=19199.
REQ-036 Queue 3 pixels, then pulse clear -> 3 pixel writes, then 19200 zero writes from 0 to 19199; pix_ready low throughout; a second clear mid-sweep has no effect; then IDLE with busy=0.
REQ-037 Assert RST at sweep address 5000 -> vwe=0 and busy=0 immediately; after release, pix_ready=1 and no further writes occur.
REQ-038 Build without PIXWR_CLEAR_EN and pulse clear -> no writes, busy stays 0.
